// File: rtl/sdram_burst_addr_gen_if.sv
// rtl/sdram_burst_addr_gen_if.sv - bus-side signal bundle for the SDRAM burst address generator
// Optional Stop input present only when BURST_TERM_EN is defined.
interface sdram_burst_addr_gen_if #(
  parameter int ROW_W  = 8,
  parameter int BANK_W = 2,
  parameter int COL_W  = 8
);
  localparam int ADDR_W  = ROW_W + BANK_W + COL_W;
  localparam int BANK_WW = (BANK_W > 0) ? BANK_W : 1;

  logic [ADDR_W-1:0]  AddrIn;
  logic [1:0]         SizeIn;
  logic               WeIn;
  logic               AddrMode;
  logic [2:0]         BurstLengthConfig;
  logic               Start;
  logic               Advance;
`ifdef BURST_TERM_EN
  logic               Stop;
`endif
  logic [ROW_W-1:0]   RowAddr;
  logic [BANK_WW-1:0] BankAddr;
  logic [COL_W-1:0]   ColAddr;
  logic [1:0]         SizeOut;
  logic               WeOut;
  logic               Busy;
  logic               Last;
  logic               Done;

  modport master (
    output AddrIn, SizeIn, WeIn, AddrMode, BurstLengthConfig, Start, Advance,
`ifdef BURST_TERM_EN
    output Stop,
`endif
    input  RowAddr, BankAddr, ColAddr, SizeOut, WeOut, Busy, Last, Done
  );

  modport slave (
    input  AddrIn, SizeIn, WeIn, AddrMode, BurstLengthConfig, Start, Advance,
`ifdef BURST_TERM_EN
    input  Stop,
`endif
    output RowAddr, BankAddr, ColAddr, SizeOut, WeOut, Busy, Last, Done
  );
endinterface

// File: rtl/sdram_burst_addr_gen.sv
// rtl/sdram_burst_addr_gen.sv - row/bank/column split and burst column stepping for the SDRAM controller
// Define BURST_TERM_EN to enable early burst termination through bus.Stop.
module sdram_burst_addr_gen #(
  parameter int ROW_W  = 8,
  parameter int BANK_W = 2,
  parameter int COL_W  = 8
) (
  input logic                  Clk,
  input logic                  Rst,
  sdram_burst_addr_gen_if.slave bus
);
  localparam int ADDR_W  = ROW_W + BANK_W + COL_W;
  localparam int BANK_WW = (BANK_W > 0) ? BANK_W : 1;
  localparam int CW1     = COL_W + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [BANK_WW-1:0]  bank_q, bank_d;
  logic [COL_W-1:0]    base_q, base_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                mode_q, mode_d;
  logic [2:0]          blc_q, blc_d;
  logic [COL_W:0]      beat_q, beat_d;
  logic                done_q, done_d;

  logic                stop;
  logic [ROW_W-1:0]    row_in;
  logic [BANK_WW-1:0]  bank_in;
  logic [COL_W-1:0]    col_in_al;
  int unsigned         il_in, il_q, bl_log, wb_log;
  logic [COL_W:0]      bl_m1;
  logic                interleave, busy, last, start_fire;

`ifdef BURST_TERM_EN
  assign stop = bus.Stop;
`else
  assign stop = 1'b0;
`endif

  function automatic int unsigned inc_log_of(input logic [1:0] size);
    return (size == 2'b00) ? 0 : (size == 2'b01) ? 1 : 2;
  endfunction

  function automatic int unsigned bl_log_of(input logic [2:0] blc, input int unsigned il);
    case (blc)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b011:  return 3;
      3'b111:  return COL_W - il;
      default: return 0;
    endcase
  endfunction

  // Bits above the wrap boundary come from the aligned start; only the low field moves.
  function automatic logic [COL_W-1:0] col_at(input logic [COL_W-1:0] base,
                                              input logic [COL_W:0]   beat,
                                              input int unsigned      il,
                                              input int unsigned      wl,
                                              input logic             inter);
    logic [COL_W:0]   mask_w, off_w;
    logic [COL_W-1:0] mask, off, low;
    mask_w = (CW1'(1) << wl) - CW1'(1);
    mask   = mask_w[COL_W-1:0];
    off_w  = beat << il;
    off    = off_w[COL_W-1:0];
    low    = inter ? (base ^ off) : (base + off);
    return (base & ~mask) | (low & mask);
  endfunction

  always_comb begin
    row_in    = bus.AddrIn[ADDR_W-1 -: ROW_W];
    bank_in   = (BANK_W > 0) ? bus.AddrIn[COL_W +: BANK_WW] : '0;
    il_in     = inc_log_of(bus.SizeIn);
    col_in_al = bus.AddrIn[COL_W-1:0] & ~((COL_W'(1) << il_in) - COL_W'(1));
    il_q      = inc_log_of(size_q);
    bl_log    = bl_log_of(blc_q, il_q);
    wb_log    = (bl_log + il_q > COL_W) ? COL_W : bl_log + il_q;
    bl_m1     = (CW1'(1) << bl_log) - CW1'(1);
    interleave = mode_q && (blc_q != 3'b111);
  end

  assign busy       = (state_q == S_BURST);
  assign last       = busy && (beat_q == bl_m1);
  assign start_fire = (state_q == S_IDLE) && bus.Start;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bank_d  = bank_q;
    base_d  = base_q;
    col_d   = col_q;
    size_d  = size_q;
    we_d    = we_q;
    mode_d  = mode_q;
    blc_d   = blc_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          row_d   = row_in;
          bank_d  = bank_in;
          base_d  = col_in_al;
          col_d   = col_in_al;
          size_d  = bus.SizeIn;
          we_d    = bus.WeIn;
          mode_d  = bus.AddrMode;
          blc_d   = bus.BurstLengthConfig;
          beat_d  = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (bus.Advance) beat_d = beat_q + CW1'(1);
        if ((bus.Advance && last) || stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (bus.Advance) begin
          col_d = col_at(base_q, beat_q + CW1'(1), il_q, wb_log, interleave);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      bank_q  <= '0;
      base_q  <= '0;
      col_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      mode_q  <= 1'b0;
      blc_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bank_q  <= bank_d;
      base_q  <= base_d;
      col_q   <= col_d;
      size_q  <= size_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      blc_q   <= blc_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

  // Zero-latency bypass lets ACTIVATE issue in the same cycle Start is seen.
  always_comb begin
    bus.RowAddr  = start_fire ? row_in      : row_q;
    bus.BankAddr = start_fire ? bank_in     : bank_q;
    bus.ColAddr  = start_fire ? col_in_al   : col_q;
    bus.SizeOut  = start_fire ? bus.SizeIn  : size_q;
    bus.WeOut    = start_fire ? bus.WeIn    : we_q;
    bus.Busy     = busy;
    bus.Last     = last;
    bus.Done     = done_q;
  end
endmodule

// File: doc/sdram_burst_addr_gen.md
Name: sdram_burst_addr_gen

Overview:
Parametrised SDRAM address generator for the unidirectional bus/SDRAM controller datapath. It splits a flat bus address into row, bank and column fields and latches size, direction and burst settings. It then steps the column through a programmable burst with sequential or interleaved ordering, wrapping on the burst boundary. A small FSM tracks beats and flags the last beat and burst completion to the SDRAM command sequencer.

Parameters:
ROW_W, 8, row address width
BANK_W, 2, bank address width (0 allowed: BankAddr tied 0, width 1)
COL_W, 8, column address width in bytes; must be >= 5
ADDR_W, ROW_W+BANK_W+COL_W, bus address width; AddrIn = {row, bank, col}

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
AddrIn  in  ADDR_W  bus address
SizeIn  in  2  00 byte, 01 halfword, 10/11 word
WeIn  in  1  1 = write burst
AddrMode  in  1  0 sequential, 1 interleaved
BurstLengthConfig  in  3  000=1, 001=2, 010=4, 011=8, 111=full page, others=1
Start  in  1  request new burst (sampled in IDLE only)
Advance  in  1  current beat consumed; step to next column
RowAddr  out  ROW_W  row address
BankAddr  out  BANK_W  bank address
ColAddr  out  COL_W  current column (byte) address
SizeOut  out  2  latched size
WeOut  out  1  latched direction
Busy  out  1  burst in progress
Last  out  1  current beat is final beat
Done  out  1  one-cycle pulse after final beat consumed

Behaviour:
- Reset (Rst=0, async): FSM=IDLE; all registers and outputs 0.
- States: IDLE, BURST. IDLE + Start -> BURST; BURST + Advance with Last=1 -> IDLE.
- Start in IDLE: latch row, bank, col, SizeIn, WeIn, AddrMode, BurstLengthConfig; beat counter = 0. Same cycle, RowAddr/BankAddr/ColAddr/SizeOut/WeOut bypass combinationally from inputs, so ACTIVATE can issue with zero latency. Other IDLE cycles: outputs hold last latched values.
- Start while Busy is ignored. Advance in IDLE is ignored. Start+Advance together in IDLE: Start wins, Advance dropped.
- Increment INC = 1/2/4 for byte/half/word. On load, the log2(INC) low column bits are cleared (forced alignment).
- Beats BL: 1/2/4/8 per encoding. Full page: BL = 2^COL_W / INC.
- Wrap boundary WB = BL*INC bytes, clamped to 2^COL_W. Column bits above log2(WB) never change during a burst.
- Sequential: low log2(WB) bits = (start_low + beat*INC) mod WB.
- Interleaved: low log2(WB) bits = start_low XOR (beat*INC). Interleaved with full page behaves as sequential.
- Each accepted Advance in BURST: beat counter +1 and ColAddr updates next cycle (registered). Counter width = COL_W+1.
- Last = Busy and beat == BL-1. BL=1: Last high in the first BURST cycle.
- Done is asserted the cycle after the final Advance, coincident with Busy falling. The next Start is accepted in that same cycle.
- Reset mid-burst aborts immediately, with no Done.

Optional Feature:
BURST_TERM_EN: adds input Stop (1 bit). Stop in BURST ends the burst: next cycle FSM=IDLE, Done pulses and ColAddr holds its value. Stop+Advance together: the beat is counted, then the burst terminates. Stop in IDLE is ignored. Without the macro there is no Stop port and every burst runs to BL beats.

Test Plan:
- Seq, word, BL=4, AddrIn col=0x08, Advance every cycle -> ColAddr 0x08,0x0C,0x00,0x04; Last on 4th beat; Done next cycle.
- Interleaved, word, BL=4, col=0x04 -> 0x04,0x00,0x0C,0x08; RowAddr/BankAddr constant = AddrIn fields.
- Full page, byte, col=0xFE, COL_W=8 -> 0xFE,0xFF,0x00,...,0xFD; 256 beats; Done after 256th Advance.
- Halfword, BL=8, col=0x13 -> aligned to 0x12; sequence 0x12,0x14,...,0x1E,0x10; SizeOut=01 throughout.
- Start while Busy, Advance in IDLE, Start+Advance in IDLE -> no state change, no column change, and Advance dropped, respectively; Rst low mid-burst -> all outputs 0 and no Done.
- BURST_TERM_EN: BL=8 seq word col=0, Stop with 3rd Advance -> 3 beats (0x00,0x04,0x08), Done next cycle, Busy low.
